// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial structural adder.
// Holds the FSM state encoding, WIDTH bounds and the counter-width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Counter width for a WIDTH-bit operand: $clog2(WIDTH), never below 1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_structural_full_add.sv
// One-bit structural adder cells: half adder, and a full adder made from two
// half adders plus an OR of their carries. Ports: a_i, b_i, ci_i -> s_o, co_o.
module half_add_structural (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module full_add_structural (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic s0;
  logic c0;
  logic c1;

  half_add_structural u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_add_structural u_ha1 (
    .a_i (s0),
    .b_i (ci_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign co_o = c0 | c1;

endmodule

// File: rtl/serial_add_structural.sv
// Bit-serial adder: one full-adder slice adds WIDTH-bit a/b LSB-first, one bit
// per clock, with valid/ready on both sides. Ports: clk, rst_n, in_valid/
// in_ready/a/b (operands), out_valid/out_ready/sum/carry (result).
// Optional: SERIAL_ADD_SUB_EN adds port 'sub' so the block computes a-b.
module serial_add_structural
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_structural: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_b;
  logic             fa_s;
  logic             fa_co;
  logic             cy_init;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  // Subtract = add inverted b with carry-in preset to 1.
  assign fa_b    = b_q[0] ^ sub_q;
  assign cy_init = sub;
`else
  assign fa_b    = b_q[0];
  assign cy_init = 1'b0;
`endif

  full_add_structural u_fa (
    .a_i  (a_q[0]),
    .b_i  (fa_b),
    .ci_i (cy_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cy_d      = cy_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d     = sub_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cy_d    = cy_init;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB; after WIDTH shifts the LSB is at bit 0.
        res_d = {fa_s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign sum   = res_q;
  assign carry = cy_q;

endmodule

// File: tb/tb_serial_add_structural.sv
// Directed bench for serial_add_structural with an expected-result queue.
// Latency, backpressure, mid-operation reset, back-to-back and subtract.
module tb_serial_add_structural;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  logic [W:0] q[$];

  serial_add_structural #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 1'b1;
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xs, input logic [W:0] exp);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("send_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sub = xs;
    q.push_back(exp);
    tick();
    hs_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    t = cyc;
    if (!ok) chk({tag, "_timeout"}, 64'(out_valid), 64'(1));
  endtask

  task automatic recv(input string tag, output int t);
    bit ok;
    logic [W:0] e;
    wait_valid(tag, t, ok);
    if (ok) begin
      if (q.size() == 0) begin
        chk({tag, "_q"}, 64'(q.size()), 64'(1));
      end else begin
        e = q.pop_front();
        chk(tag, 64'({carry, sum}), 64'(e));
      end
      tick();
    end
  endtask

  initial begin
    int t1;
    int t2;
    bit ok;
    logic [W:0] e;

    #3;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'({carry, sum}), 64'(0));
    #14 rst_n = 1'b1;
    tick();

    // Handshake edge -> out_valid after WIDTH further edges (cycle WIDTH+1).
    send(8'h00, 8'h00, 1'b0, 9'h000);
    recv("zero", t1);
    chk("latency", 64'(t1 - hs_cyc), 64'(W));
    chk("idle_after", 64'({in_ready, out_valid}), 64'(2'b10));

    send(8'hFF, 8'h01, 1'b0, 9'h100);
    recv("ff_01", t1);
    send(8'hA5, 8'h5A, 1'b0, 9'h0FF);
    recv("a5_5a", t1);

    // Backpressure in DONE, with in_valid toggling on a=0x11.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));
    wait_valid("bp", t1, ok);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'h11;
      b = 8'h00;
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_res", 64'({carry, sum}), 64'(e));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", 64'({in_ready, out_valid}), 64'(2'b10));
    tick();
    chk("bp_no_capture", 64'(in_ready), 64'(1));

    // Reset in the 4th SHIFT cycle aborts the operation.
    send(8'h7F, 8'h01, 1'b0, 9'h000);
    void'(q.pop_back());
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_res", 64'({carry, sum}), 64'(0));
    #5 rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    send(8'h03, 8'h04, 1'b0, 9'h007);
    recv("after_rst", t1);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    a = 8'h3C;
    b = 8'hD9;
    sub = 1'b0;
    q.push_back(model(8'h3C, 8'hD9, 1'b0));
    tick();
    a = 8'h81;
    b = 8'h92;
    q.push_back(model(8'h81, 8'h92, 1'b0));
    recv("b2b_1", t1);
    recv("b2b_2", t2);
    in_valid = 1'b0;
    chk("b2b_gap", 64'(t2 - t1), 64'(W + 2));

`ifdef SERIAL_ADD_SUB_EN
    send(8'h05, 8'h07, 1'b1, 9'h0FE);
    recv("sub_5_7", t1);
    send(8'h07, 8'h05, 1'b1, 9'h102);
    recv("sub_7_5", t1);
    send(8'h07, 8'h05, 1'b0, 9'h00C);
    recv("add_after_sub", t1);
`endif

    chk("q_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_structural.md
Name: serial_add_structural

Overview:
- Bit-serial adder built on the structural half-adder cell.
- Two cascaded half adders plus an OR gate form one full-adder slice. A registered carry lets that slice add two WIDTH-bit operands LSB-first, one bit per clock.
- Sits between an operand source (valid/ready) and a result consumer (valid/ready). Trades latency for the area of a single slice.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  sum bits
- carry  output  1  carry-out of MSB (borrow-not when subtracting)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (on rst_n low, immediately): state=IDLE, in_ready=1, out_valid=0, sum=0, carry=0, internal carry register=0, bit counter=0, operand shift registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a/b into shift registers, clear carry register (set to 1 if subtract active), clear counter, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle:
    - the slice adds a_sr[0], b_sr[0] and carry_reg;
    - the sum bit shifts into the MSB of the result register (LSB ends at bit 0 after WIDTH shifts);
    - a_sr and b_sr shift right;
    - carry_reg takes the slice carry;
    - counter increments.
    - When counter==WIDTH-1 in this cycle, go to DONE.
  - DONE: out_valid=1. sum=result register, carry=carry_reg. Hold outputs stable until out_ready. On out_valid&out_ready, go to IDLE next cycle.
- Latency: operand handshake at cycle 0; out_valid asserted at cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- in_valid while not in IDLE is ignored; no operand is captured, and the source must hold until in_ready.
- A handshake in DONE does not allow acceptance of new operands in the same cycle; in_ready rises the cycle after.
- Width rule: the result is exactly WIDTH+1 bits ({carry,sum}). No truncation and no sign extension.
- Reset mid-SHIFT or mid-DONE aborts the operation; no result is emitted, and the block returns to IDLE with reset values.
- sum/carry hold their last values in IDLE; they are only meaningful while out_valid=1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b at the operand handshake.
  - sub=1 inverts each b bit into the slice and presets carry_reg to 1, computing a-b in two's complement.
  - carry=1 means no borrow.
- Undefined:
  - No sub port; the block is add-only and the carry register is cleared at capture.

Decomposition:
- Package serial_add_pkg holds:
  - FSM state typedef (IDLE, SHIFT, DONE; 2-bit encoding 00/01/10);
  - localparam CNT_W = $clog2(WIDTH) helper;
  - WIDTH legality bounds.
- One natural sub-module: full_add_structural, built from two half_add_structural instances and an OR of their carries. It is instantiated once and forms the whole combinational datapath slice.

Test Plan:
- Reset, then a=8'h00, b=8'h00 handshake -> out_valid at cycle 9; sum=8'h00, carry=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1. Also a=8'hA5, b=8'h5A -> sum=8'hFF, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum/carry stay stable; in_ready stays 0. Toggling in_valid with a=8'h11 meanwhile has no effect. Release -> in_ready=1 next cycle.
- Assert rst_n=0 at cycle 4 of SHIFT with a=8'h7F, b=8'h01 -> outputs go to reset values immediately. After release, a new 8'h03+8'h04 returns sum=8'h07, carry=0.
- With SERIAL_ADD_SUB_EN, sub=1:
  - a=8'h05, b=8'h07 -> sum=8'hFE, carry=0;
  - a=8'h07, b=8'h05 -> sum=8'h02, carry=1.
- Back-to-back with out_ready=1 and in_valid=1 continuously, two operations -> second result appears exactly WIDTH+2 cycles after the first.
